mc_control_fsm: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder of the MIPS-subset core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready-handshake to memory.
- Drives the datapath strobes per state and has a memory-timeout watchdog.
- Covers the same opcode set: R-type, j, jal, addi, addiu, andi, xori, ori, beq, bne, blez, bgtz, bgez, lw, sw, lb, sb, slti, lui.

---
 rtl/mc_control_fsm.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences FETCH/DECODE/EXEC/MEM/WB
// with a ready handshake to memory, drives the datapath strobes and traps on timeouts.
module mc_control_fsm #(
    parameter int OPC_W    = 6,
    parameter int FUNC_W   = 6,
    parameter int ALU_OP_W = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPC_W-1:0]    inst,
    input  logic [FUNC_W-1:0]   func,
    input  logic                mem_ready,
    output logic [FUNC_W-1:0]   func_q,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write_en,
    output logic                mem_byte,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                branch,
    output logic [2:0]          branch_cond,
    output logic                jump,
    output logic                reg_write,
    output logic                illegal,
    output logic                bus_err,
    output logic                busy
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    // Last wait-counter value before the watchdog fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'h00);
    localparam logic [OPC_W-1:0] OP_BGEZ  = OPC_W'(6'h01);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'h02);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(6'h03);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'h04);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'h05);
    localparam logic [OPC_W-1:0] OP_BLEZ  = OPC_W'(6'h06);
    localparam logic [OPC_W-1:0] OP_BGTZ  = OPC_W'(6'h07);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'h08);
    localparam logic [OPC_W-1:0] OP_ADDIU = OPC_W'(6'h09);
    localparam logic [OPC_W-1:0] OP_SLTI  = OPC_W'(6'h0A);
    localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'(6'h0C);
    localparam logic [OPC_W-1:0] OP_ORI   = OPC_W'(6'h0D);
    localparam logic [OPC_W-1:0] OP_XORI  = OPC_W'(6'h0E);
    localparam logic [OPC_W-1:0] OP_LUI   = OPC_W'(6'h0F);
    localparam logic [OPC_W-1:0] OP_LB    = OPC_W'(6'h20);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'h23);
    localparam logic [OPC_W-1:0] OP_SB    = OPC_W'(6'h28);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'h2B);

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(3'd0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(3'd1);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(3'd2);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3'd3);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(3'd4);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(3'd5);
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(3'd6);
    localparam logic [ALU_OP_W-1:0] ALU_FUNC = ALU_OP_W'(3'd7);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_BAD
    } cls_t;

    function automatic cls_t op_class(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE:                                   op_class = C_RTYPE;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI:                    op_class = C_IALU;
            OP_LB, OP_LW:                               op_class = C_LOAD;
            OP_SB, OP_SW:                               op_class = C_STORE;
            OP_BGEZ, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  op_class = C_BRANCH;
            OP_J:                                       op_class = C_JUMP;
            OP_JAL:                                     op_class = C_JAL;
            default:                                    op_class = C_BAD;
        endcase
    endfunction

    function automatic logic [ALU_OP_W-1:0] ialu_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_ANDI: ialu_op = ALU_AND;
            OP_ORI:  ialu_op = ALU_OR;
            OP_XORI: ialu_op = ALU_XOR;
            OP_SLTI: ialu_op = ALU_SLT;
            OP_LUI:  ialu_op = ALU_LUI;
            default: ialu_op = ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] br_cond(input logic [OPC_W-1:0] op);
        case (op)
            OP_BNE:  br_cond = 3'd1;
            OP_BLEZ: br_cond = 3'd2;
            OP_BGTZ: br_cond = 3'd3;
            OP_BGEZ: br_cond = 3'd4;
            default: br_cond = 3'd0;
        endcase
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_s;
    logic [OPC_W-1:0]    op_q_r;
    logic [FUNC_W-1:0]   func_q_r;
    logic                illegal_r, bus_err_r;
    logic                set_illegal_s, set_bus_err_s;
    cls_t                cls_q_s;

    assign cls_q_s = op_class(op_q_r);

    // State, wait counter, latched instruction fields and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= '0;
            op_q_r     <= '0;
            func_q_r   <= '0;
            illegal_r  <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if (set_illegal_s) illegal_r <= 1'b1;
            if (set_bus_err_s) bus_err_r <= 1'b1;
            if (state_r == S_DECODE) begin
                op_q_r   <= inst;
                func_q_r <= func;
            end
        end
    end

    // Next-state, watchdog and strobe decode; rst forces every output low in the same cycle.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        set_illegal_s = 1'b0;
        set_bus_err_s = 1'b0;
        func_q        = '0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write_en  = 1'b0;
        mem_byte      = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        branch        = 1'b0;
        branch_cond   = 3'd0;
        jump          = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        bus_err       = 1'b0;
        busy          = 1'b0;
        if (rst) begin
            state_s    = S_FETCH;
            wait_cnt_s = '0;
        end else begin
            func_q  = func_q_r;
            illegal = illegal_r;
            bus_err = bus_err_r;
            busy    = (state_r != S_FETCH) || (wait_cnt_r != '0);
            case (state_r)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_s    = S_DECODE;
                        wait_cnt_s = '0;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        state_s       = S_TRAP;
                        set_bus_err_s = 1'b1;
                        wait_cnt_s    = '0;
                    end else begin
                        wait_cnt_s = wait_cnt_r + CNT_W'(1'b1);
                    end
                end
                S_DECODE: begin
                    if (op_class(inst) == C_BAD) begin
                        state_s       = S_TRAP;
                        set_illegal_s = 1'b1;
                    end else begin
                        state_s = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls_q_s)
                        C_RTYPE: begin
                            alu_op  = ALU_FUNC;
                            state_s = S_WB;
                        end
                        C_IALU: begin
                            alu_op  = ialu_op(op_q_r);
                            alu_src = 1'b1;
                            state_s = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_op  = ALU_ADD;
                            alu_src = 1'b1;
                            state_s = S_MEM;
                        end
                        C_BRANCH: begin
                            branch      = 1'b1;
                            alu_op      = ALU_SUB;
                            branch_cond = br_cond(op_q_r);
                            state_s     = S_FETCH;
                        end
                        C_JUMP: begin
                            jump    = 1'b1;
                            state_s = S_FETCH;
                        end
                        C_JAL: begin
                            jump       = 1'b1;
                            reg_dst    = 2'd2;
                            mem_to_reg = 2'd2;
                            reg_write  = 1'b1;
                            state_s    = S_FETCH;
                        end
                        default: begin
                            state_s       = S_TRAP;
                            set_illegal_s = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_byte     = (op_q_r == OP_LB) || (op_q_r == OP_SB);
                    mem_read     = (cls_q_s == C_LOAD);
                    mem_write_en = (cls_q_s != C_LOAD);
                    if (mem_ready) begin
                        state_s    = (cls_q_s == C_LOAD) ? S_WB : S_FETCH;
                        wait_cnt_s = '0;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        state_s       = S_TRAP;
                        set_bus_err_s = 1'b1;
                        wait_cnt_s    = '0;
                    end else begin
                        wait_cnt_s = wait_cnt_r + CNT_W'(1'b1);
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls_q_s == C_RTYPE) ? 2'd1 : 2'd0;
                    mem_to_reg = (cls_q_s == C_LOAD) ? 2'd1 : 2'd0;
                    state_s    = S_FETCH;
                end
                S_TRAP: begin
                    state_s = S_TRAP;
                end
                default: begin
                    state_s = S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: a per-instruction cycle-script model built from
// the opcode table is compared against the DUT outputs every cycle.
module tb_mc_control_fsm;
    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] inst = 6'd0;
    logic [5:0] func = 6'd0;
    logic       mem_ready = 1'b0;
    logic [5:0] func_q;
    logic       pc_write, ir_write, mem_read, mem_write_en, mem_byte;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       branch;
    logic [2:0] branch_cond;
    logic       jump, reg_write, illegal, bus_err, busy;

    always #5 clk = ~clk;

    mc_control_fsm #(.OPC_W(6), .FUNC_W(6), .ALU_OP_W(4), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .inst(inst), .func(func), .mem_ready(mem_ready),
        .func_q(func_q), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write_en(mem_write_en), .mem_byte(mem_byte), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .branch(branch),
        .branch_cond(branch_cond), .jump(jump), .reg_write(reg_write),
        .illegal(illegal), .bus_err(bus_err), .busy(busy)
    );

    typedef struct packed {
        logic       pc_write, ir_write, mem_read, mem_write_en, mem_byte;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic [2:0] branch_cond;
        logic       jump, reg_write, busy, illegal, bus_err;
    } outv_t;

    // One scripted cycle: expected outputs, mem_ready to drive (2 = random), decode flag.
    typedef struct {
        outv_t      exp;
        logic [1:0] mr;
        logic       dec;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] fq;
    } step_t;

    outv_t obs;
    assign obs = {pc_write, ir_write, mem_read, mem_write_en, mem_byte, reg_dst, mem_to_reg,
                  alu_src, alu_op, branch, branch_cond, jump, reg_write, busy, illegal, bus_err};

    step_t      sq[$];
    int         total = 0;
    int         bad = 0;
    logic       m_ill = 1'b0;
    logic       m_be = 1'b0;
    logic [5:0] m_fq = 6'd0;
    logic [5:0] legal [19] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                               6'h20, 6'h23, 6'h28, 6'h2B};

    // Classes: 0 R-type, 1 I-ALU, 2 load, 3 store, 4 branch, 5 j, 6 jal.
    function automatic void lookup(input logic [5:0] op, output logic ok, output int cls,
                                   output logic [3:0] aop, output logic [2:0] cond);
        ok = 1'b1; cls = 0; aop = 4'd0; cond = 3'd0;
        case (op)
            6'h00: begin cls = 0; aop = 4'd7; end
            6'h08, 6'h09: begin cls = 1; aop = 4'd0; end
            6'h0C: begin cls = 1; aop = 4'd2; end
            6'h0D: begin cls = 1; aop = 4'd3; end
            6'h0E: begin cls = 1; aop = 4'd4; end
            6'h0A: begin cls = 1; aop = 4'd5; end
            6'h0F: begin cls = 1; aop = 4'd6; end
            6'h20, 6'h23: cls = 2;
            6'h28, 6'h2B: cls = 3;
            6'h04: begin cls = 4; cond = 3'd0; end
            6'h05: begin cls = 4; cond = 3'd1; end
            6'h06: begin cls = 4; cond = 3'd2; end
            6'h07: begin cls = 4; cond = 3'd3; end
            6'h01: begin cls = 4; cond = 3'd4; end
            6'h02: cls = 5;
            6'h03: cls = 6;
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic outv_t base(input logic b);
        outv_t v;
        v = '0;
        v.busy = b;
        v.illegal = m_ill;
        v.bus_err = m_be;
        return v;
    endfunction

    task automatic push(input outv_t v, input logic [1:0] mr, input logic dec,
                        input logic [5:0] op, input logic [5:0] fn);
        step_t s;
        s.exp = v; s.mr = mr; s.dec = dec; s.op = op; s.fn = fn; s.fq = m_fq;
        sq.push_back(s);
    endtask

    // Scripts one instruction; a wait count >= MAX_WAIT ends it with a watchdog trap.
    task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        outv_t v; logic ok; int cls; logic [3:0] aop; logic [2:0] cond;
        for (int k = 0; k < wf && k < MAX_WAIT; k++) begin
            v = base(k > 0); v.mem_read = 1'b1; push(v, 2'd0, 1'b0, op, fn);
        end
        if (wf >= MAX_WAIT) begin m_be = 1'b1; return; end
        v = base(wf > 0); v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        push(v, 2'd1, 1'b0, op, fn);
        push(base(1'b1), 2'd2, 1'b1, op, fn);
        m_fq = fn;
        lookup(op, ok, cls, aop, cond);
        if (!ok) begin m_ill = 1'b1; return; end
        v = base(1'b1);
        case (cls)
            0, 1: begin v.alu_op = aop; v.alu_src = (cls == 1); end
            2, 3: begin v.alu_op = 4'd0; v.alu_src = 1'b1; end
            4: begin v.branch = 1'b1; v.alu_op = 4'd1; v.branch_cond = cond; end
            5: v.jump = 1'b1;
            6: begin v.jump = 1'b1; v.reg_dst = 2'd2; v.mem_to_reg = 2'd2; v.reg_write = 1'b1; end
            default: ;
        endcase
        push(v, 2'd2, 1'b0, op, fn);
        if (cls == 2 || cls == 3) begin
            for (int k = 0; k <= wm && k < MAX_WAIT; k++) begin
                v = base(1'b1);
                v.mem_read = (cls == 2); v.mem_write_en = (cls == 3);
                v.mem_byte = (op == 6'h20) || (op == 6'h28);
                push(v, (k == wm) ? 2'd1 : 2'd0, 1'b0, op, fn);
            end
            if (wm >= MAX_WAIT) begin m_be = 1'b1; return; end
        end
        if (cls <= 2) begin
            v = base(1'b1); v.reg_write = 1'b1;
            v.reg_dst = (cls == 0) ? 2'd1 : 2'd0;
            v.mem_to_reg = (cls == 2) ? 2'd1 : 2'd0;
            push(v, 2'd2, 1'b0, op, fn);
        end
    endtask

    task automatic trap_tail(input int n);
        for (int k = 0; k < n; k++) push(base(1'b1), 2'd2, 1'b0, 6'd0, 6'd0);
    endtask

    task automatic play(input string name);
        step_t s;
        int idx;
        idx = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            mem_ready = (s.mr == 2'd2) ? 1'($urandom) : s.mr[0];
            inst = s.dec ? s.op : 6'($urandom);
            func = s.dec ? s.fn : 6'($urandom);
            #1;
            total++;
            if (obs !== s.exp) begin
                bad++;
                $display("FAIL %s step %0d: outputs got %h want %h", name, idx, obs, s.exp);
            end
            total++;
            if (func_q !== s.fq) begin
                bad++;
                $display("FAIL %s step %0d func_q: got %h want %h", name, idx, func_q, s.fq);
            end
            idx++;
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'($urandom); inst = 6'($urandom); func = 6'($urandom);
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL %s outputs during rst: got %h want 0", name, obs);
        end
        total++;
        if (func_q !== 6'd0) begin
            bad++;
            $display("FAIL %s func_q during rst: got %h want 0", name, func_q);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; m_ill = 1'b0; m_be = 1'b0; m_fq = 6'd0;
    endtask

    task automatic test_reset();
        do_reset("reset");
        build_instr(6'h00, 6'h25, 0, 0);
        play("reset_first_fetch");
    endtask

    task automatic test_add();
        build_instr(6'h00, 6'h20, 0, 0);
        play("add");
    endtask

    task automatic test_load_wait();
        build_instr(6'h23, 6'h11, 0, 2);
        play("lw_wait");
        build_instr(6'h20, 6'h05, 3, 1);
        play("lb_wait");
    endtask

    task automatic test_branches();
        logic [5:0] ops [5] = '{6'h04, 6'h07, 6'h01, 6'h05, 6'h06};
        foreach (ops[i]) begin
            build_instr(ops[i], 6'($urandom), 0, 0);
            play("branch");
        end
    endtask

    task automatic test_jal_sb();
        build_instr(6'h03, 6'h3C, 0, 0);
        play("jal");
        build_instr(6'h28, 6'h0A, 0, 1);
        play("sb");
    endtask

    task automatic test_illegal();
        logic [5:0] op; logic ok; int cls; logic [3:0] aop; logic [2:0] cond;
        for (int i = 0; i < 3; i++) begin
            op = 6'h3F;
            if (i > 0) begin
                do begin
                    op = 6'($urandom);
                    lookup(op, ok, cls, aop, cond);
                end while (ok);
            end
            build_instr(op, 6'($urandom), int'($urandom_range(0, 2)), 0);
            trap_tail(20);
            play("illegal_trap");
            do_reset("illegal_rst");
            build_instr(6'h00, 6'h20, 0, 0);
            play("illegal_resume");
        end
    endtask

    task automatic test_timeout();
        build_instr(6'h00, 6'h22, MAX_WAIT - 1, 0);
        play("fetch_wait_max_ok");
        build_instr(6'h00, 6'h22, MAX_WAIT, 0);
        trap_tail(5);
        play("fetch_timeout");
        do_reset("fetch_timeout_rst");
        build_instr(6'h2B, 6'h01, 0, MAX_WAIT - 1);
        play("mem_wait_max_ok");
        build_instr(6'h23, 6'h02, 0, MAX_WAIT);
        trap_tail(5);
        play("mem_timeout");
        do_reset("mem_timeout_rst");
    endtask

    task automatic test_reset_mid_mem();
        build_instr(6'h2B, 6'h07, 0, 1);
        void'(sq.pop_back());
        play("sw_before_rst");
        do_reset("sw_mid_mem_rst");
        build_instr(6'h00, 6'h20, 1, 0);
        play("after_mid_mem_rst");
    endtask

    task automatic test_back_to_back();
        int wf, wm;
        for (int i = 0; i < 60; i++) begin
            wf = ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : int'($urandom_range(0, 3));
            build_instr(legal[$urandom_range(0, 18)], 6'($urandom), wf, wm);
        end
        play("back_to_back");
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branches();
        test_jal_sb();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
